// File: rtl/adder_seq_if.sv
// Bus bundle for adder_seq: ALU-side request/result signals plus the link to the
// shared 8-bit ripple adder. The sequencer uses the slave modport.
interface adder_seq_if #(
   parameter int NBYTES = 4
);
   localparam int W = 8 * NBYTES;

   // Handshake: start is sampled only while idle (busy=0, done=0); busy stays high
   // for the NBYTES byte cycles; done pulses for one cycle when result/c/v/z are
   // valid, and those hold until the next accepted start overwrites them.
   logic         start;
   logic         op_sub;
   logic         cin;
   logic [W-1:0] opa;
   logic [W-1:0] opb;

   logic [7:0]   add_a;
   logic [7:0]   add_b;
   logic         add_ci;
   logic [7:0]   add_y;
   logic         add_c;
   logic         add_v;

   logic [W-1:0] result;
   logic         c_out;
   logic         v_out;
   logic         z_out;
   logic         busy;
   logic         done;

   modport master (
      output start, op_sub, cin, opa, opb,
      output add_y, add_c, add_v,
      input  add_a, add_b, add_ci,
      input  result, c_out, v_out, z_out, busy, done
   );

   modport slave (
      input  start, op_sub, cin, opa, opb,
      input  add_y, add_c, add_v,
      output add_a, add_b, add_ci,
      output result, c_out, v_out, z_out, busy, done
   );
endinterface

// File: rtl/adder_seq.sv
// Multi-precision add/subtract sequencer: walks NBYTES bytes LSB-first through one
// external 8-bit adder, chaining its carry and assembling the wide result and flags.
module adder_seq #(
   parameter int NBYTES = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   adder_seq_if.slave  bus,
   output logic [1:0]  state_dbg
);
   localparam int W    = 8 * NBYTES;
   localparam int IDXW = $clog2(NBYTES);
   localparam logic [IDXW-1:0] LAST = IDXW'(NBYTES - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIN  = 2'd2
   } state_t;

   state_t                  state;
   logic [IDXW-1:0]         idx;
   logic [NBYTES-1:0][7:0]  a_q;
   logic [NBYTES-1:0][7:0]  b_q;
   logic [NBYTES-1:0][7:0]  res_q;
   logic [NBYTES-1:0][7:0]  res_nx;
   logic                    sub_q;
   logic                    carry;
   logic                    c_q;
   logic                    v_q;
   logic                    z_q;
   logic                    busy_q;
   logic                    done_q;
   logic                    last_byte;

   assign last_byte = (idx == LAST);

   // The adder only sees live operands in RUN so idle cycles present a quiet bus.
   always_comb begin
      bus.add_a  = 8'd0;
      bus.add_b  = 8'd0;
      bus.add_ci = 1'b0;
      if (state == RUN) begin
         bus.add_a  = a_q[idx];
         bus.add_b  = sub_q ? ~b_q[idx] : b_q[idx];
         bus.add_ci = carry;
      end
   end

   // Full post-write result, so Z can be registered on the same edge as the last byte.
   always_comb begin
      res_nx      = res_q;
      res_nx[idx] = bus.add_y;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         idx    <= '0;
         a_q    <= '0;
         b_q    <= '0;
         res_q  <= '0;
         sub_q  <= 1'b0;
         carry  <= 1'b0;
         c_q    <= 1'b0;
         v_q    <= 1'b0;
         z_q    <= 1'b0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done_q <= 1'b0;
               if (bus.start) begin
                  a_q    <= bus.opa;
                  b_q    <= bus.opb;
                  sub_q  <= bus.op_sub;
                  carry  <= bus.cin;
                  idx    <= '0;
                  busy_q <= 1'b1;
                  state  <= RUN;
               end
            end
            RUN: begin
               res_q <= res_nx;
               carry <= bus.add_c;
               if (last_byte) begin
                  // The top byte's adder V is the signed overflow of the whole word.
                  c_q    <= bus.add_c;
                  v_q    <= bus.add_v;
                  z_q    <= (res_nx == '0);
                  busy_q <= 1'b0;
                  done_q <= 1'b1;
                  state  <= FIN;
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            FIN: begin
               done_q <= 1'b0;
               idx    <= '0;
               state  <= IDLE;
            end
            default: begin
               busy_q <= 1'b0;
               done_q <= 1'b0;
               idx    <= '0;
               state  <= IDLE;
            end
         endcase
      end
   end

   assign bus.result = W'(res_q);
   assign bus.c_out  = c_q;
   assign bus.v_out  = v_q;
   assign bus.z_out  = z_q;
   assign bus.busy   = busy_q;
   assign bus.done   = done_q;
   assign state_dbg  = state;
endmodule

// File: tb/tb_adder_seq.sv
// Bench for adder_seq: models the external 8-bit adder, runs a vector table of
// add/subtract cases, then hand sequences for ignored START, operand change and reset.
module tb_adder_seq;
   localparam int NBYTES = 4;

   logic       clk;
   logic       rst_n;
   logic [1:0] state_dbg;

   adder_seq_if #(.NBYTES(NBYTES)) bus ();

   adder_seq #(.NBYTES(NBYTES)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus),
      .state_dbg (state_dbg)
   );

   // Behavioural 8-bit ripple adder standing in for the shared instance.
   assign {bus.add_c, bus.add_y} = {1'b0, bus.add_a} + {1'b0, bus.add_b} + {8'd0, bus.add_ci};
   assign bus.add_v = (bus.add_a[7] == bus.add_b[7]) && (bus.add_y[7] != bus.add_a[7]);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        sub;
      logic        cin;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] r;
      logic        c;
      logic        v;
      logic        z;
   } vec_t;

   vec_t        vecs [9];
   int          n_checks = 0;
   int          n_fail   = 0;
   logic [31:0] prev_result;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic run_op(input vec_t t, input string tag);
      logic [31:0] bsel;
      int          busy_cnt;
      @(negedge clk);
      bus.op_sub = t.sub;
      bus.cin    = t.cin;
      bus.opa    = t.a;
      bus.opb    = t.b;
      bus.start  = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      bsel = t.sub ? ~t.b : t.b;
      check({tag, " add_a byte0"}, {24'd0, bus.add_a}, {24'd0, t.a[7:0]});
      check({tag, " add_b byte0"}, {24'd0, bus.add_b}, {24'd0, bsel[7:0]});
      check({tag, " add_ci byte0"}, {31'd0, bus.add_ci}, {31'd0, t.cin});
      busy_cnt = 0;
      for (int i = 0; i < NBYTES; i++) begin
         if (i > 0) @(negedge clk);
         if (i == 1)
            check({tag, " unwritten bytes hold"}, {8'd0, bus.result[31:8]}, {8'd0, prev_result[31:8]});
         if (bus.busy && !bus.done) busy_cnt++;
      end
      check({tag, " busy cycles"}, 32'(busy_cnt), 32'(NBYTES));
      @(negedge clk);
      check({tag, " done"}, {31'd0, bus.done}, 32'd1);
      check({tag, " busy at done"}, {31'd0, bus.busy}, 32'd0);
      check({tag, " result"}, bus.result, t.r);
      check({tag, " c_out"}, {31'd0, bus.c_out}, {31'd0, t.c});
      check({tag, " v_out"}, {31'd0, bus.v_out}, {31'd0, t.v});
      check({tag, " z_out"}, {31'd0, bus.z_out}, {31'd0, t.z});
      prev_result = t.r;
      @(negedge clk);
      check({tag, " done one cycle"}, {31'd0, bus.done}, 32'd0);
      check({tag, " result hold"}, bus.result, t.r);
   endtask

   initial begin
      int   k;
      int   done_cnt;
      int   busy_seen;
      vec_t rv;

      //          sub   cin   a             b             result        c     v     z
      vecs[0] = '{1'b0, 1'b0, 32'h000000FF, 32'h00000001, 32'h00000100, 1'b0, 1'b0, 1'b0};
      vecs[1] = '{1'b0, 1'b0, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1, 1'b0};
      vecs[2] = '{1'b0, 1'b0, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 1'b1};
      vecs[3] = '{1'b1, 1'b1, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0};
      vecs[4] = '{1'b1, 1'b1, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0};
      vecs[5] = '{1'b0, 1'b0, 32'h01020304, 32'h10203040, 32'h11223344, 1'b0, 1'b0, 1'b0};
      vecs[6] = '{1'b0, 1'b1, 32'h000000FF, 32'h00000000, 32'h00000100, 1'b0, 1'b0, 1'b0};
      vecs[7] = '{1'b1, 1'b0, 32'h00000010, 32'h00000001, 32'h0000000E, 1'b1, 1'b0, 1'b0};
      vecs[8] = '{1'b1, 1'b1, 32'h00000005, 32'h00000005, 32'h00000000, 1'b1, 1'b0, 1'b1};

      rst_n      = 1'b0;
      bus.start  = 1'b0;
      bus.op_sub = 1'b0;
      bus.cin    = 1'b0;
      bus.opa    = '0;
      bus.opb    = '0;
      prev_result = 32'd0;

      @(negedge clk);
      check("reset result", bus.result, 32'd0);
      check("reset flags", {28'd0, bus.c_out, bus.v_out, bus.z_out, bus.busy}, 32'd0);
      check("reset done", {31'd0, bus.done}, 32'd0);
      check("reset state", {30'd0, state_dbg}, 32'd0);
      check("reset adder drive", {15'd0, bus.add_a, bus.add_b, bus.add_ci}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 9; i++)
         run_op(vecs[i], $sformatf("vec%0d", i));

      // Reset while byte 2 is on the adder; earlier bytes already hold nonzero data.
      @(negedge clk);
      bus.op_sub = 1'b0;
      bus.cin    = 1'b0;
      bus.opa    = 32'h01020304;
      bus.opb    = 32'h10203040;
      bus.start  = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("pre-reset partial result", {16'd0, bus.result[15:0]}, 32'h00003344);
      rst_n = 1'b0;
      #1;
      check("async reset result", bus.result, 32'd0);
      check("async reset flags", {28'd0, bus.c_out, bus.v_out, bus.z_out, bus.busy}, 32'd0);
      check("async reset done", {31'd0, bus.done}, 32'd0);
      check("async reset state", {30'd0, state_dbg}, 32'd0);
      check("async reset adder drive", {15'd0, bus.add_a, bus.add_b, bus.add_ci}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      prev_result = 32'd0;
      run_op(vecs[5], "post-reset add");

      // START and operand changes during RUN, then START during the DONE cycle.
      rv = vecs[0];
      @(negedge clk);
      bus.op_sub = rv.sub;
      bus.cin    = rv.cin;
      bus.opa    = rv.a;
      bus.opb    = rv.b;
      bus.start  = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      @(negedge clk);
      bus.start  = 1'b1;
      bus.opa    = 32'h12345678;
      bus.opb    = 32'hFFFFFFFF;
      bus.op_sub = 1'b1;
      bus.cin    = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      k = 0;
      while (!bus.done && k < 10) begin
         @(negedge clk);
         k++;
      end
      check("busy-start done seen", {31'd0, bus.done}, 32'd1);
      check("busy-start result", bus.result, rv.r);
      check("busy-start flags", {29'd0, bus.c_out, bus.v_out, bus.z_out}, {29'd0, rv.c, rv.v, rv.z});
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      check("done-start ignored busy", {31'd0, bus.busy}, 32'd0);
      check("done-start ignored state", {30'd0, state_dbg}, 32'd0);
      done_cnt  = 0;
      busy_seen = 0;
      for (int j = 0; j < 8; j++) begin
         @(negedge clk);
         if (bus.done) done_cnt++;
         if (bus.busy) busy_seen++;
      end
      check("no queued done", 32'(done_cnt), 32'd0);
      check("no queued busy", 32'(busy_seen), 32'd0);
      check("result hold idle", bus.result, rv.r);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
